ram_gen_dp: RTL

//  Parametrised two-port word RAM for data/instruction memories, replacing the single-port

---
 rtl/ram_gen_dp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_gen_dp.sv
// Two-port word RAM: port A read/write with byte lanes, port B read-only.
// Registered reads, optional zeroing sweep after reset or on request.
module ram_gen_dp #(
    parameter     INIT_FILE    = "",
    parameter int DP           = 512,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int AW           = 32,
    parameter bit CLEAR_ON_RST = 1'b0,
    parameter bit RD_BYPASS    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          ready,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [MW-1:0] a_sel,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          b_err
);

    localparam int CW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [AW-1:0] DP_A = AW'(DP);
    localparam logic [CW-1:0] LAST = CW'(DP - 1);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [DW-1:0] mem [DP];

    logic          a_acc;
    logic          b_acc;
    logic          a_in;
    logic          b_in;
    logic          a_wr;
    logic          hit;
    logic [CW-1:0] a_idx;
    logic [CW-1:0] b_idx;
    logic [DW-1:0] bit_mask;
    logic [DW-1:0] a_old;
    logic [DW-1:0] a_new;

    // Expand lane enables to a per-bit mask; a partial top lane keeps the rest.
    for (genvar i = 0; i < DW; i++) begin : g_mask
        localparam int L = ((i / 8) < MW) ? (i / 8) : (MW - 1);
        assign bit_mask[i] = a_sel[L];
    end

    // Request acceptance, range check and merged write word.
    always_comb begin
        a_acc = a_req & ready;
        b_acc = b_req & ready;
        a_in  = (a_addr < DP_A);
        b_in  = (b_addr < DP_A);
        a_idx = a_addr[CW-1:0];
        b_idx = b_addr[CW-1:0];
        a_wr  = a_acc & a_we & a_in;
        hit   = a_wr & b_in & (a_idx == b_idx);
        a_old = mem[a_idx];
        a_new = (a_old & ~bit_mask) | (a_wdata & bit_mask);
    end

    // Array update: sweep writes zero, otherwise port A lane write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (a_wr) begin
                mem[a_idx] <= a_new;
            end
        end
    end

    // Sweep control and the ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RST ? CLEAR : RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Port A registered read data and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            a_rdata  <= '0;
        end else begin
            a_rvalid <= a_acc & ~a_we;
            a_err    <= a_acc & ~a_in;
            if (a_acc & ~a_we) begin
                a_rdata <= a_in ? mem[a_idx] : '0;
            end
        end
    end

    // Port B registered read data, optionally forwarding a same-cycle A write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            b_rvalid <= b_acc;
            b_err    <= b_acc & ~b_in;
            if (b_acc) begin
                if (!b_in) begin
                    b_rdata <= '0;
                end else if (RD_BYPASS && hit) begin
                    b_rdata <= a_new;
                end else begin
                    b_rdata <= mem[b_idx];
                end
            end
        end
    end

endmodule
